// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//
// UART receiver that turns 8N1 frames on RX into bytes. When
// UART_RX_PARITY_EN is defined it receives 8E1 frames instead and reports
// even-parity mismatches on PERR. RX must already be synchronized to CLK.
// There is no synchronizer inside this block.
//
// Configuration macro:
//   UART_RX_PARITY_EN  - defined: start + 8 data + parity + stop, PERR live
//                        undefined: start + 8 data + stop, PERR tied 0
//
// Parameters:
//   CLK_DIV  - CLK cycles per bit period (>= 4)
//   CNT_W    - width of the bit-timing counter (2**CNT_W > CLK_DIV)
//
// Ports:
//   CLK    in   clock
//   RESET  in   synchronous, active-high reset
//   RX     in   synchronized serial input, idle high
//   DATA   out  last received byte (first bit on the line is DATA[0])
//   VALID  out  one-cycle strobe: DATA/FERR/PERR were updated
//   FERR   out  framing error of the last byte (stop bit sampled low)
//   PERR   out  parity error of the last byte (0 without parity option)
//   BUSY   out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int CLK_DIV = 434,
    parameter int CNT_W   = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FERR,
    output logic       PERR,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_t;

    // The first load lands the sample point in the middle of the start bit.
    // Every later load spaces samples one full bit period apart.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       sr, sr_n;
    logic [7:0]       data_q, data_n;
    logic             valid_q, valid_n;
    logic             ferr_q, ferr_n;
    logic             expired;

`ifdef UART_RX_PARITY_EN
    logic             par_q, par_n;
    logic             perr_q, perr_n;
`endif

    assign expired = (cnt == '0);

    // State and datapath registers. A reset also aborts any frame that is
    // in progress, so no VALID is produced for it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sr      <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            sr      <= sr_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_n;
            perr_q  <= perr_n;
`endif
        end
    end

    // Next-state logic. The counter is reloaded on every expiry, so it never
    // wraps. DATA is written only when the stop bit is sampled, which means a
    // partially received byte is never visible on DATA.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        sr_n      = sr;
        data_n    = data_q;
        valid_n   = 1'b0;
        ferr_n    = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_n     = par_q;
        perr_n    = perr_q;
`endif

        case (state)
            ST_IDLE: begin
                if (!RX) begin
                    state_n = ST_START;
                    cnt_n   = HALF_LOAD;
                end
            end

            // A start bit that is already high again at mid-bit is treated
            // as a glitch. The receiver drops back to idle without output.
            ST_START: begin
                if (expired) begin
                    if (RX) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n   = ST_DATA;
                        cnt_n     = FULL_LOAD;
                        bit_idx_n = 3'd0;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (expired) begin
                    sr_n  = {RX, sr[7:1]};
                    cnt_n = FULL_LOAD;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            // Even parity: the eight data bits and the parity bit together
            // must contain an even number of ones. Odd means an error.
            ST_PARITY: begin
                if (expired) begin
                    par_n   = ^{sr, RX};
                    cnt_n   = FULL_LOAD;
                    state_n = ST_STOP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
`endif

            // The receiver leaves the stop bit at its midpoint. This lets a
            // back-to-back start edge in the second half of the stop bit be
            // caught. A low stop bit goes to BREAK, so a line held low cannot
            // start a new frame.
            ST_STOP: begin
                if (expired) begin
                    data_n  = sr;
                    valid_n = 1'b1;
                    ferr_n  = ~RX;
`ifdef UART_RX_PARITY_EN
                    perr_n  = par_q;
`endif
                    cnt_n   = '0;
                    state_n = RX ? ST_IDLE : ST_BREAK;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            ST_BREAK: begin
                if (RX) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign DATA  = data_q;
    assign VALID = valid_q;
    assign FERR  = ferr_q;
    assign BUSY  = (state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign PERR  = perr_q;
`else
    assign PERR  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//
// Self-checking bench for uart_rx_frame with CLK_DIV = 16. A table of frames
// is sent back-to-back. Each frame's expected byte and status go into a
// scoreboard queue, and a monitor pops and compares them on every VALID.
// Hand-written sequences cover the corner cases: idle line, start glitch,
// framing error with a held-low line, and a reset in the middle of a frame.
// Define UART_RX_PARITY_EN for both bench and DUT to test the 8E1 build.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

    localparam int CLK_DIV = 16;
    localparam int NVEC    = 8;

    logic       CLK;
    logic       RESET;
    logic       RX;
    logic [7:0] DATA;
    logic       VALID;
    logic       FERR;
    logic       PERR;
    logic       BUSY;

    typedef struct {
        logic [7:0] data;
        logic       par_bit;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t exp_q [$];

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   valid_count  = 0;
    logic prev_valid   = 1'b0;

    uart_rx_frame #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (8)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .RX    (RX),
        .DATA  (DATA),
        .VALID (VALID),
        .FERR  (FERR),
        .PERR  (PERR),
        .BUSY  (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Compare one value and keep the pass/fail counts.
    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    // Drive one bit for one full bit period. Changes happen #1 after posedge.
    task automatic driveBit(input logic b);
        RX = b;
        repeat (CLK_DIV) @(posedge CLK);
        #1;
    endtask

    // Send one frame. When push_exp is set, the expected result goes into
    // the scoreboard first.
    task automatic applyStimulus(input logic [7:0] data, input logic par_bit,
                                 input logic stop_bit, input logic push_exp,
                                 input exp_t expect_val);
        if (push_exp) exp_q.push_back(expect_val);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
        driveBit(par_bit);
`else
        if (par_bit === 1'bx) RX = 1'b1;
`endif
        driveBit(stop_bit);
    endtask

    // Wait until every expected result has been matched, with a cycle limit.
    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40 * CLK_DIV) begin
            @(posedge CLK);
            n++;
        end
        #1;
        checkOutput(name, 8'(exp_q.size()), 8'd0);
    endtask

    // Scoreboard monitor. It samples on the falling edge, away from the
    // DUT's active edge.
    always @(negedge CLK) begin
        if (RESET) begin
            prev_valid = 1'b0;
        end else begin
            if (VALID) begin
                exp_t e;
                valid_count++;
                checkOutput("valid_one_cycle", {7'd0, prev_valid}, 8'd0);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_valid: got VALID with DATA=0x%02h, expected no VALID", DATA);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_data", DATA, e.data);
                    checkOutput("sb_ferr", {7'd0, FERR}, {7'd0, e.ferr});
                    checkOutput("sb_perr", {7'd0, PERR}, {7'd0, e.perr});
                end
            end
            prev_valid = VALID;
        end
    end

    // Global time limit, so the bench can never hang.
    initial begin
        #(400_000);
        $display("[TB] FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        exp_t e;
        int   vc;

        // Frame table: {data, parity bit, stop bit, exp data, exp ferr, exp perr}
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[5] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

        RX    = 1'b1;
        RESET = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        checkOutput("reset_valid", {7'd0, VALID}, 8'd0);
        checkOutput("reset_busy",  {7'd0, BUSY},  8'd0);
        checkOutput("reset_data",  DATA,          8'h00);
        checkOutput("reset_ferr",  {7'd0, FERR},  8'd0);
        checkOutput("reset_perr",  {7'd0, PERR},  8'd0);
        RESET = 1'b0;

        // Idle line for 100 cycles.
        repeat (100) @(posedge CLK);
        #1;
        checkOutput("idle_no_valid", 8'(valid_count), 8'd0);
        checkOutput("idle_busy",     {7'd0, BUSY},    8'd0);
        checkOutput("idle_data",     DATA,            8'h00);

        // Back-to-back frames from the table.
        for (int i = 0; i < NVEC; i++) begin
            e.data = vecs[i].exp_data;
            e.ferr = vecs[i].exp_ferr;
`ifdef UART_RX_PARITY_EN
            e.perr = vecs[i].exp_perr;
`else
            e.perr = 1'b0;
`endif
            applyStimulus(vecs[i].data, vecs[i].par_bit, vecs[i].stop_bit, 1'b1, e);
        end
        RX = 1'b1;
        waitDrain("table_drain");
        checkOutput("table_valid_count", 8'(valid_count), 8'(NVEC));

        // Start glitch: low for 6 cycles, then high again.
        vc = valid_count;
        RX = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("glitch_busy_high", {7'd0, BUSY}, 8'd1);
        repeat (3) @(posedge CLK);
        #1;
        RX = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        checkOutput("glitch_no_valid", 8'(valid_count), 8'(vc));
        checkOutput("glitch_busy_low", {7'd0, BUSY},    8'd0);

        // Framing error: 0x81 with a low stop bit, then the line held low.
        vc     = valid_count;
        e.data = 8'h81;
        e.ferr = 1'b1;
        e.perr = 1'b0;
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, e);
        repeat (40) @(posedge CLK);
        #1;
        checkOutput("break_one_valid", 8'(valid_count), 8'(vc + 1));
        checkOutput("break_busy",      {7'd0, BUSY},    8'd1);
        checkOutput("ferr_sticky",     {7'd0, FERR},    8'd1);
        checkOutput("break_data",      DATA,            8'h81);
        RX = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        checkOutput("break_release_busy", {7'd0, BUSY},    8'd0);
        checkOutput("break_no_retrigger", 8'(valid_count), 8'(vc + 1));
        checkOutput("break_queue_empty",  8'(exp_q.size()), 8'd0);

        // Reset pulse after the 4th data bit of 0xFF, then a normal 0x12.
        vc = valid_count;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b1);
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #0;
        checkOutput("abort_busy", {7'd0, BUSY}, 8'd0);
        checkOutput("abort_data", DATA,         8'h00);
        repeat (6 * CLK_DIV) @(posedge CLK);
        #1;
        checkOutput("abort_no_valid", 8'(valid_count), 8'(vc));
        e.data = 8'h12;
        e.ferr = 1'b0;
        e.perr = 1'b0;
        applyStimulus(8'h12, 1'b0, 1'b1, 1'b1, e);
        RX = 1'b1;
        waitDrain("after_abort_drain");
        checkOutput("after_abort_valid", 8'(valid_count), 8'(vc + 1));

        repeat (10) @(posedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
